seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential unsigned integer divider; the inverse of the combinational
//  5x5 multiplier in the arithmetic blocks.
//  Computes quotient and remainder by restoring long division, one
//  quotient bit per clock, under a start/done handshake.
//  Used as the DIV path beside the multiplier in the recitation datapath.
// PARAMETERS
//  WIDTH  5  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clock        in   1      single clock, rising edge
//  reset_n      in   1      asynchronous active-low reset
//  start        in   1      request; sampled only in IDLE or DONE
//  dividend     in   WIDTH  unsigned dividend, sampled with start
//  divisor      in   WIDTH  unsigned divisor, sampled with start
//  busy         out  1      high while state==RUN
//  done         out  1      one-cycle pulse; result valid
//  quotient     out  WIDTH  result, held until next completion
//  remainder    out  WIDTH  result, held until next completion
//  div_by_zero  out  1      flag for last result; held like quotient
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE. busy, done, quotient, remainder
//   and div_by_zero are all 0. Internal regs are cleared.
//  FSM states: IDLE, RUN, DONE. All outputs are registered.
//  IDLE/DONE with start=1 and divisor!=0, at edge k:
//   - Capture operands into the internal A (dividend shift reg) and D.
//   - Set R=0, cnt=WIDTH, state->RUN.
//  IDLE/DONE with start=1 and divisor==0, at edge k:
//   - state->DONE.
//   - quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
//  RUN, each edge performs one iteration (R is WIDTH+1 bits):
//   - T = {R[WIDTH-1:0], A[WIDTH-1]} - {1'b0, D}.
//   - If T is non-negative: R=T and the new quotient bit is 1.
//     Otherwise R keeps the shifted value and the new quotient bit is 0.
//   - A shifts left and takes the new quotient bit in its LSB.
//   - cnt decrements.
//   - On the iteration where cnt==1: load quotient/remainder from A/R,
//     set div_by_zero=0, state->DONE.
//  Latency: done=1 in the cycle after edge k+WIDTH (k+1 for divide by
//   zero). Back-to-back ops give one result per WIDTH+1 cycles.
//  DONE lasts exactly one cycle:
//   - start=1 begins a new op (as from IDLE); otherwise state->IDLE.
//  done = (state==DONE). busy = (state==RUN).
//  start in RUN is ignored. Operand changes in RUN have no effect.
//  quotient, remainder and div_by_zero change only on the edge entering
//   DONE. They hold their old values through IDLE and RUN.
//  Invariant: dividend == quotient*divisor + remainder, and
//   remainder < divisor, whenever divisor != 0.
//  reset_n low mid-RUN aborts the op immediately; no done pulse follows.
// TESTING (WIDTH=5)
//  1. 23/4 -> done 5 cycles after start edge; q=5, r=3, dbz=0;
//     busy high for exactly 5 cycles.
//  2. 31/1 -> q=31, r=0. 3/7 -> q=0, r=3. 0/9 -> q=0, r=0.
//     31/31 -> q=1, r=0.
//  3. 9/0 -> done 1 cycle after start; q=31, r=9, dbz=1.
//     Then 10/3 -> q=3, r=1, dbz=0.
//  4. start=1 with 17/5 pulsed 2 cycles into an active 23/4 op ->
//     ignored; result is 5,3, and only one done pulse occurs.
//  5. start held high continuously with fixed operands -> done pulses
//     every 6 cycles, results correct each time.
//  6. reset_n low mid-RUN -> all outputs 0 asynchronously; no done.
//     A new op after release completes correctly.
//  Plus: exhaustive 32x32 sweep checked against the invariant.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock under a
// start/done handshake, with a divide-by-zero fast path that completes in one edge.
module seq_divider #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a, a_nx;
  logic [WIDTH-1:0] d, d_nx;
  logic [WIDTH-1:0] r, r_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] q_nx, rem_nx;
  logic             dbz_nx;
  logic [WIDTH:0]   shifted, diff;
  logic             qbit;

  // Partial remainder is always < divisor, so its top bit is stored implicitly
  // as zero; the extra bit only exists in the trial subtraction.
  always_comb begin
    shifted  = {1'b0, r, a[WIDTH-1]};
    shifted  = {r, a[WIDTH-1]};
    diff     = shifted - {1'b0, d};
    qbit     = ~diff[WIDTH];
    state_nx = state;
    a_nx     = a;
    d_nx     = d;
    r_nx     = r;
    cnt_nx   = cnt;
    q_nx     = quotient;
    rem_nx   = remainder;
    dbz_nx   = div_by_zero;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_nx = DONE;
            q_nx     = '1;
            rem_nx   = dividend;
            dbz_nx   = 1'b1;
          end else begin
            a_nx     = dividend;
            d_nx     = divisor;
            r_nx     = '0;
            cnt_nx   = CW'(WIDTH);
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        a_nx   = {a[WIDTH-2:0], qbit};
        r_nx   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = DONE;
          q_nx     = a_nx;
          rem_nx   = r_nx;
          dbz_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      a           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      a           <= a_nx;
      d           <= d_nx;
      r           <= r_nx;
      cnt         <= cnt_nx;
      quotient    <= q_nx;
      remainder   <= rem_nx;
      div_by_zero <= dbz_nx;
      busy        <= (state_nx == RUN);
      done        <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=5); inputs driven and
// outputs sampled on the falling clock edge.
module tb_seq_divider;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [4:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Issues one operation and returns at the falling edge where done is seen.
  // lat = rising edges after the start-sampling edge until DONE is entered.
  task automatic run_op(input logic [4:0] x, input logic [4:0] y,
                        output int lat, output int busy_n, output bit to);
    dividend = x; divisor = y; start = 1'b1;
    lat = 0; busy_n = 0; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        lat = i; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock); @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 5'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", quotient); end
    checks++; if (remainder !== 5'd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int lat, bn; bit to;
    run_op(5'd23, 5'd4, lat, bn, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    checks++; if (bn != 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", bn); end
    checks++; if (quotient !== 5'd5 || remainder !== 5'd3 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_23_4: got q=%0d r=%0d dbz=%b expected q=5 r=3 dbz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_table();
    logic [4:0] tx[4] = '{5'd31, 5'd3, 5'd0, 5'd31};
    logic [4:0] ty[4] = '{5'd1, 5'd7, 5'd9, 5'd31};
    logic [4:0] tq[4] = '{5'd31, 5'd0, 5'd0, 5'd1};
    logic [4:0] tr[4] = '{5'd0, 5'd3, 5'd0, 5'd0};
    int lat, bn; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(tx[i], ty[i], lat, bn, to);
      checks++; if (to || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
        errors++; $display("FAIL table_%0d_%0d: got q=%0d r=%0d dbz=%b timeout=%b expected q=%0d r=%0d dbz=0",
                           tx[i], ty[i], quotient, remainder, div_by_zero, to, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_hold();
    bit bad = 1'b0;
    int n = 0;
    dividend = 5'd23; divisor = 5'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (busy && n < 10) begin
      if (quotient !== 5'd1 || remainder !== 5'd0) bad = 1'b1;
      dividend = 5'(n); divisor = 5'(n + 1);
      n++;
      @(negedge clock);
    end
    checks++; if (bad) begin errors++; $display("FAIL hold_in_run: got changed result expected q=1 r=0"); end
    checks++; if (done !== 1'b1 || quotient !== 5'd5 || remainder !== 5'd3) begin
      errors++; $display("FAIL hold_operand_change: got done=%b q=%0d r=%0d expected done=1 q=5 r=3", done, quotient, remainder);
    end
    @(negedge clock);
  endtask

  task automatic test_div_zero();
    int lat, bn; bit to;
    run_op(5'd9, 5'd0, lat, bn, to);
    checks++; if (to || lat != 0) begin errors++; $display("FAIL dbz_latency: got %0d timeout=%b expected 0", lat, to); end
    checks++; if (quotient !== 5'd31 || remainder !== 5'd9 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_9_0: got q=%0d r=%0d dbz=%b expected q=31 r=9 dbz=1", quotient, remainder, div_by_zero);
    end
    run_op(5'd10, 5'd3, lat, bn, to);
    checks++; if (to || lat != 5 || quotient !== 5'd3 || remainder !== 5'd1 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL dbz_then_10_3: got lat=%0d q=%0d r=%0d dbz=%b expected lat=5 q=3 r=1 dbz=0",
                         lat, quotient, remainder, div_by_zero);
    end
    @(negedge clock);
  endtask

  task automatic test_start_in_run();
    int dones = 0;
    dividend = 5'd23; divisor = 5'd4; start = 1'b1;
    for (int i = 1; i < 15; i++) begin
      @(negedge clock);
      start = (i == 2);
      if (i == 2) begin dividend = 5'd17; divisor = 5'd5; end
      if (done) begin
        dones++;
        checks++; if (i != 6 || quotient !== 5'd5 || remainder !== 5'd3) begin
          errors++; $display("FAIL start_in_run_result: got at=%0d q=%0d r=%0d expected at=6 q=5 r=3", i, quotient, remainder);
        end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL start_in_run_pulses: got %0d expected 1", dones); end
  endtask

  task automatic test_back_to_back();
    int dones = 0, last = 0;
    dividend = 5'd13; divisor = 5'd4; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        checks++; if (i - last != 6 || quotient !== 5'd3 || remainder !== 5'd1) begin
          errors++; $display("FAIL b2b_pulse: got gap=%0d q=%0d r=%0d expected gap=6 q=3 r=1", i - last, quotient, remainder);
        end
        last = i;
      end
    end
    checks++; if (dones != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", dones); end
    start = 1'b0;
    for (int i = 0; i < 20 && (busy || done); i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run();
    int dones = 0, lat, bn; bit to;
    dividend = 5'd23; divisor = 5'd4; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 5'd0 || remainder !== 5'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
                         busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done || busy) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", dones); end
    run_op(5'd10, 5'd3, lat, bn, to);
    checks++; if (to || quotient !== 5'd3 || remainder !== 5'd1 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL midrun_recover: got q=%0d r=%0d dbz=%b expected q=3 r=1 dbz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clock);
  endtask

  task automatic test_sweep();
    int lat, bn; bit to;
    int bad = 0;
    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        run_op(5'(x), 5'(y), lat, bn, to);
        if (to) bad++;
        else if (y == 0) begin
          if (quotient !== 5'd31 || remainder !== 5'(x) || div_by_zero !== 1'b1) bad++;
        end else if (x != int'(quotient) * y + int'(remainder) || int'(remainder) >= y || div_by_zero !== 1'b0) begin
          bad++;
          if (bad < 5) $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                                x, y, quotient, remainder, x / y, x % y);
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sweep_invariant: got %0d bad results expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_table();
    test_hold();
    test_div_zero();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
